// File: rtl/control_types.sv
// Shared memory-access types for the CPU data path and the data-memory arbiter.
package control_types;

  // Access size and sign extension, shared by loads and stores.
  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-ported data memory: CPU-priority with a
// DMA starvation bound and an optional DMA burst lock. Grants are same-cycle.
module dmem_arbiter
  import control_types::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr_en,
  input  mem_op_t     cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_wr_en,
  input  mem_op_t     dma_op,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        mem_wr_en,
  output mem_op_t     mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(BURST_MAX);

  arb_owner_t         owner_q, owner_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic dma_forced;
  logic dma_locked;

  assign dma_forced = (wait_cnt_q == WAIT_LIMIT);
  assign dma_locked = (owner_q == ARB_DMA) & dma_lock & (burst_cnt_q < BURST_LIMIT);

  // Reset gates both grants so an in-flight write cannot commit on the reset edge.
  assign dma_gnt   = ~reset & dma_req & (~cpu_req | dma_forced | dma_locked);
  assign cpu_gnt   = ~reset & cpu_req & ~dma_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign cpu_rdata = mem_data_out;
  assign dma_rdata = mem_data_out;

  always_comb begin
    if (dma_gnt) begin
      mem_wr_en   = dma_wr_en;
      mem_op      = dma_op;
      mem_addr    = dma_addr;
      mem_data_in = dma_wdata;
    end else begin
      mem_wr_en   = cpu_wr_en & cpu_gnt;
      mem_op      = cpu_op;
      mem_addr    = cpu_addr;
      mem_data_in = cpu_wdata;
    end
  end

  always_comb begin
    owner_d = ARB_IDLE;
    if (dma_gnt) begin
      owner_d = ARB_DMA;
    end else if (cpu_gnt) begin
      owner_d = ARB_CPU;
    end

    wait_cnt_d = '0;
    if (dma_req & ~dma_gnt) begin
      wait_cnt_d = dma_forced ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    burst_cnt_d = '0;
    if (dma_gnt) begin
      burst_cnt_d = (burst_cnt_q == BURST_LIMIT) ? burst_cnt_q : burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= ARB_IDLE;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a cycle-level reference model,
// with a byte-addressed memory standing in for data_memory.
module tb_dmem_arbiter;
  import control_types::*;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_wr_en;
  mem_op_t     cpu_op;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_lock, dma_wr_en;
  mem_op_t     dma_op;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        mem_wr_en;
  mem_op_t     mem_op;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_wr_en(dma_wr_en), .dma_op(dma_op),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fmt(input mem_op_t op, input logic [31:0] w);
    case (op)
      MEM_B:   return {{24{w[7]}}, w[7:0]};
      MEM_BU:  return {24'h0, w[7:0]};
      MEM_H:   return {{16{w[15]}}, w[15:0]};
      MEM_HU:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic int op_bytes(input mem_op_t op);
    case (op)
      MEM_B, MEM_BU: return 1;
      MEM_H, MEM_HU: return 2;
      default:       return 4;
    endcase
  endfunction

  // Stand-in for data_memory: combinational read, write on the rising edge.
  logic [7:0] dev_mem [0:1023] = '{default: 8'h00};
  logic [9:0] dev_a;
  assign dev_a = mem_addr[9:0];
  assign mem_data_out = fmt(mem_op, {dev_mem[dev_a + 10'd3], dev_mem[dev_a + 10'd2],
                                     dev_mem[dev_a + 10'd1], dev_mem[dev_a]});
  always @(posedge clk) begin
    if (mem_wr_en) begin
      dev_mem[dev_a] <= mem_data_in[7:0];
      if (op_bytes(mem_op) >= 2) dev_mem[dev_a + 10'd1] <= mem_data_in[15:8];
      if (op_bytes(mem_op) == 4) begin
        dev_mem[dev_a + 10'd2] <= mem_data_in[23:16];
        dev_mem[dev_a + 10'd3] <= mem_data_in[31:24];
      end
    end
  end

  // Reference model: expected memory contents plus arbitration history.
  logic [7:0] ref_mem [0:1023] = '{default: 8'h00};
  int m_last;      // 0 nobody, 1 CPU, 2 DMA granted last cycle
  int m_denied;    // consecutive cycles a requesting DMA was refused
  int m_streak;    // consecutive DMA grants, saturating
  int run;         // observed consecutive DMA refusals
  int n_assert, n_fail;
  logic        obs_cpu, obs_dma, obs_stall, obs_wr;
  logic [31:0] obs_cpu_rdata;

  function automatic logic [31:0] ref_read(input mem_op_t op, input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return fmt(op, {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]});
  endfunction

  task automatic ref_write(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < op_bytes(op); k++) ref_mem[a[9:0] + 10'(k)] = d[8*k +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic eg_dma, eg_cpu, eg_wr;
    @(negedge clk);
    eg_dma = !reset && dma_req &&
             (!cpu_req || m_denied >= MAX_WAIT || (m_last == 2 && dma_lock && m_streak < BURST_MAX));
    eg_cpu = !reset && cpu_req && !eg_dma;
    eg_wr  = eg_dma ? dma_wr_en : (eg_cpu && cpu_wr_en);
    obs_cpu = cpu_gnt; obs_dma = dma_gnt; obs_stall = cpu_stall; obs_wr = mem_wr_en;
    obs_cpu_rdata = cpu_rdata;
    check("cpu_gnt", 32'(cpu_gnt), 32'(eg_cpu));
    check("dma_gnt", 32'(dma_gnt), 32'(eg_dma));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_cpu));
    check("mem_wr_en", 32'(mem_wr_en), 32'(eg_wr));
    check("exclusive", 32'(cpu_gnt & dma_gnt), 32'd0);
    if (eg_dma) begin
      check("mem_addr_dma", mem_addr, dma_addr);
      check("mem_op_dma", 32'(mem_op), 32'(dma_op));
      if (dma_wr_en) check("mem_wdata_dma", mem_data_in, dma_wdata);
      else check("dma_rdata", dma_rdata, ref_read(dma_op, dma_addr));
    end else if (eg_cpu) begin
      check("mem_addr_cpu", mem_addr, cpu_addr);
      check("mem_op_cpu", 32'(mem_op), 32'(cpu_op));
      if (cpu_wr_en) check("mem_wdata_cpu", mem_data_in, cpu_wdata);
      else check("cpu_rdata", cpu_rdata, ref_read(cpu_op, cpu_addr));
    end
    if (!reset && dma_req && !dma_gnt) run++;
    else run = 0;
    if (dma_req) check("dma_wait_bound", 32'(run <= MAX_WAIT), 32'd1);
    if (cpu_gnt || dma_gnt)
      $display("t=%0t cpu_gnt=%b dma_gnt=%b addr=%h wr=%b wdata=%h rdata=%h",
               $time, cpu_gnt, dma_gnt, mem_addr, mem_wr_en, mem_data_in, mem_data_out);
    @(posedge clk);
    if (reset) begin
      m_last = 0; m_denied = 0; m_streak = 0;
    end else begin
      if (eg_dma && dma_wr_en) ref_write(dma_op, dma_addr, dma_wdata);
      if (eg_cpu && cpu_wr_en) ref_write(cpu_op, cpu_addr, cpu_wdata);
      m_last   = eg_dma ? 2 : (eg_cpu ? 1 : 0);
      m_denied = (dma_req && !eg_dma) ? ((m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT) : 0;
      m_streak = eg_dma ? ((m_streak < BURST_MAX) ? m_streak + 1 : BURST_MAX) : 0;
    end
    #1;
  endtask

  task automatic rand_cmd(output mem_op_t op, output logic [31:0] a, output logic [31:0] d);
    case ($urandom_range(0, 4))
      0: op = MEM_B;
      1: op = MEM_BU;
      2: op = MEM_H;
      3: op = MEM_HU;
      default: op = MEM_W;
    endcase
    a = 32'($urandom_range(0, 255));
    if (op_bytes(op) == 2) a[0] = 1'b0;
    if (op_bytes(op) == 4) a[1:0] = 2'b00;
    d = $urandom;
  endtask

  task automatic cpu_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cpu_req = 1; cpu_wr_en = 0; cpu_op = MEM_W; cpu_addr = a;
    cycle();
    check(tag, obs_cpu_rdata, exp);
    cpu_req = 0;
  endtask

  initial begin
    logic got;
    n_assert = 0; n_fail = 0; m_last = 0; m_denied = 0; m_streak = 0; run = 0;
    obs_cpu = 0; obs_dma = 0; obs_stall = 0; obs_wr = 0; obs_cpu_rdata = '0;
    reset = 1;
    cpu_req = 1; cpu_wr_en = 1; cpu_op = MEM_W; cpu_addr = 32'h40; cpu_wdata = 32'h11;
    dma_req = 1; dma_lock = 0; dma_wr_en = 1; dma_op = MEM_W; dma_addr = 32'h44; dma_wdata = 32'h22;
    #1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("rst_cpu_gnt", 32'(obs_cpu), 32'd0);
      check("rst_dma_gnt", 32'(obs_dma), 32'd0);
      check("rst_stall", 32'(obs_stall), 32'd1);
      check("rst_wr_en", 32'(obs_wr), 32'd0);
    end
    reset = 0; dma_req = 0;

    // CPU only: write then read back.
    cpu_req = 1; cpu_wr_en = 1; cpu_op = MEM_W; cpu_addr = 32'h100; cpu_wdata = 32'h12345678;
    cycle();
    check("cpu_only_wr_gnt", 32'(obs_cpu), 32'd1);
    check("cpu_only_wr_stall", 32'(obs_stall), 32'd0);
    cpu_wr_en = 0;
    cycle();
    check("cpu_only_rd_gnt", 32'(obs_cpu), 32'd1);
    check("cpu_only_rdata", obs_cpu_rdata, 32'h12345678);
    cpu_req = 0;

    // Idle DMA byte write merges into the stored word.
    dma_req = 1; dma_wr_en = 1; dma_op = MEM_B; dma_addr = 32'h100; dma_wdata = 32'h000000AA;
    cycle();
    check("idle_dma_gnt", 32'(obs_dma), 32'd1);
    dma_req = 0;
    cpu_read_check("byte_merge", 32'h100, 32'h123456AA);
    cycle();

    // Starvation: CPU gets 0..3, DMA forced in at 4, CPU again at 5.
    cpu_req = 1; cpu_wr_en = 0; cpu_op = MEM_W; cpu_addr = 32'h100;
    dma_req = 1; dma_wr_en = 1; dma_op = MEM_W; dma_addr = 32'h180; dma_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("starve_dma_c%0d", i), 32'(obs_dma), 32'(i == 4));
      check($sformatf("starve_stall_c%0d", i), 32'(obs_stall), 32'(i == 4));
    end
    cpu_req = 0; dma_req = 0;
    cycle();

    // Burst lock: forced grant at 4 then locked through 11, CPU at 12 and 13.
    begin
      int k;
      k = 0;
      cpu_req = 1; cpu_addr = 32'h100; cpu_wr_en = 0;
      dma_req = 1; dma_lock = 1; dma_wr_en = 1; dma_op = MEM_W;
      for (int i = 0; i < 14; i++) begin
        dma_addr = 32'h200 + 32'(4 * k); dma_wdata = 32'hB0000000 + 32'(k);
        cycle();
        check($sformatf("burst_dma_c%0d", i), 32'(obs_dma), 32'(i >= 4 && i <= 11));
        if (obs_dma) k++;
      end
      cpu_req = 0; dma_req = 0; dma_lock = 0;
      for (int j = 0; j < 8; j++)
        cpu_read_check($sformatf("burst_mem%0d", j), 32'h200 + 32'(4 * j), 32'hB0000000 + 32'(j));
    end

    // Reset during a locked DMA write: the write must not land.
    dma_req = 1; dma_lock = 1; dma_wr_en = 1; dma_op = MEM_W;
    dma_addr = 32'h300; dma_wdata = 32'h1; cycle();
    dma_addr = 32'h304; dma_wdata = 32'h2; cycle();
    dma_addr = 32'h308; dma_wdata = 32'h55; reset = 1;
    cycle();
    check("rst_mid_dma_gnt", 32'(obs_dma), 32'd0);
    check("rst_mid_cpu_gnt", 32'(obs_cpu), 32'd0);
    check("rst_mid_wr_en", 32'(obs_wr), 32'd0);
    reset = 0;
    cpu_req = 1; cpu_wr_en = 0; cpu_op = MEM_W; cpu_addr = 32'h100;
    dma_addr = 32'h30C; dma_wdata = 32'h66;
    cycle();
    check("post_rst_cpu_first", 32'(obs_cpu), 32'd1);
    cpu_req = 0;
    got = obs_dma;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = obs_dma;
    end
    check("post_rst_dma_served", 32'(got), 32'd1);
    dma_req = 0; dma_lock = 0;
    cpu_read_check("rst_write_dropped", 32'h308, 32'h0);
    cpu_read_check("post_rst_write", 32'h30C, 32'h66);

    // Random traffic; commands held until granted.
    for (int n = 0; n < 1000; n++) begin
      if (!cpu_req || obs_cpu) begin
        cpu_req = ($urandom_range(0, 99) < 65);
        cpu_wr_en = $urandom_range(0, 1) == 1;
        rand_cmd(cpu_op, cpu_addr, cpu_wdata);
      end
      if (!dma_req || obs_dma) begin
        dma_req = ($urandom_range(0, 99) < 50);
        dma_wr_en = $urandom_range(0, 1) == 1;
        rand_cmd(dma_op, dma_addr, dma_wdata);
      end
      dma_lock = $urandom_range(0, 3) != 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
